vga_timing_gen: RTL

Parametrised VGA raster timing generator. It produces horizontal and vertical counters, sync pulses, a display enable, and frame/line strobes for any resolution. Every output advances on a pixel clock-enable, so the block runs on either a dedicated pixel clock or a faster system clock. A configurable delay line shifts the sync and enable outputs to match the latency of downstream pixel-fetch pipelines. It sits directly below the display top level and replaces the fixed 640x480 sync generator.

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/vga_timing_gen_if.sv | 27 ++
 rtl/vga_timing_gen_ce_delay_line.sv | 34 +++
 rtl/vga_timing_gen.sv | 112 +++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing types, mode presets and the total-period helper.
// Imported by the timing generator and by display-level code.
package vga_timing_pkg;

   typedef struct packed {
      int unsigned active;
      int unsigned fp;
      int unsigned sync;
      int unsigned bp;
   } vga_timing_t;

   typedef struct packed {
      vga_timing_t h;
      vga_timing_t v;
   } vga_mode_t;

   localparam vga_mode_t VGA_640x480_60 = '{
      h: '{active: 640, fp: 16, sync: 96,  bp: 48},
      v: '{active: 480, fp: 10, sync: 2,   bp: 33}
   };

   localparam vga_mode_t VGA_800x600_60 = '{
      h: '{active: 800, fp: 40, sync: 128, bp: 88},
      v: '{active: 600, fp: 1,  sync: 4,   bp: 23}
   };

   function automatic int unsigned total(input vga_timing_t t);
      return t.active + t.fp + t.sync + t.bp;
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel clock-enable towards the generator,
// counters, strobes and delayed sync/enable back to the consumer.
interface vga_timing_gen_if #(
   parameter int CNT_W = 10
);
   logic             pix_ce;
   logic [CNT_W-1:0] h_count;
   logic [CNT_W-1:0] v_count;
   logic             display_en;
   logic             line_start;
   logic             frame_start;
   logic             h_sync_d;
   logic             v_sync_d;
   logic             display_en_d;

   modport master (
      input  pix_ce,
      output h_count, v_count, display_en, line_start, frame_start,
      output h_sync_d, v_sync_d, display_en_d
   );

   modport slave (
      output pix_ce,
      input  h_count, v_count, display_en, line_start, frame_start,
      input  h_sync_d, v_sync_d, display_en_d
   );
endinterface

// File: rtl/vga_timing_gen_ce_delay_line.sv
// Clock-enable gated shift register with a per-bit reset value;
// DEPTH = 0 degenerates to a wire.
module ce_delay_line #(
   parameter int               WIDTH   = 1,
   parameter int               DEPTH   = 0,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             ce,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   if (DEPTH == 0) begin : g_bypass
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, reset_n, ce};
      assign q = d;
   end else begin : g_shift
      logic [WIDTH-1:0] stage_p [DEPTH];

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) stage_p[i] <= RST_VAL;
         end else if (ce) begin
            stage_p[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage_p[i] <= stage_p[i-1];
         end
      end

      assign q = stage_p[DEPTH-1];
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: counters, sync, display enable
// and line/frame strobes advancing on pix_ce, plus a latency-matching delay line.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int H_POL    = 0,
   parameter int V_POL    = 0,
   parameter int CNT_W    = 10,
   parameter int LATENCY  = 0
) (
   input logic              clk,
   input logic              reset_n,
   vga_timing_gen_if.master vga
);

   localparam vga_timing_t H_TIM = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
   localparam vga_timing_t V_TIM = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
   localparam int H_TOTAL = int'(total(H_TIM));
   localparam int V_TOTAL = int'(total(V_TIM));

   if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
       V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
      $fatal(1, "vga_timing_gen: every timing parameter must be >= 1");
   end
   if (CNT_W < 1 || CNT_W > 30 || H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_width
      $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
   end
   if (LATENCY < 0 || LATENCY > 8) begin : g_bad_latency
      $fatal(1, "vga_timing_gen: LATENCY must be 0..8");
   end

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic             H_ON     = (H_POL != 0);
   localparam logic             V_ON     = (V_POL != 0);

   logic             pix_ce;
   logic [CNT_W-1:0] h_count, v_count;
   logic [CNT_W-1:0] h_next, v_next;
   logic             h_wrap;
   logic             display_en, line_start, frame_start;
   logic             h_sync, v_sync;
   logic [2:0]       dly;

   assign pix_ce = vga.pix_ce;

   always_comb begin
      h_wrap = (h_count == H_LAST);
      h_next = h_wrap ? '0 : h_count + CNT_W'(1);
      v_next = v_count;
      if (h_wrap) v_next = (v_count == V_LAST) ? '0 : v_count + CNT_W'(1);
   end

   // Decode stage: flags are computed from the next counts so they line up
   // with the counter value they describe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h_count     <= H_LAST;
         v_count     <= V_LAST;
         display_en  <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         h_sync      <= ~H_ON;
         v_sync      <= ~V_ON;
      end else if (pix_ce) begin
         h_count     <= h_next;
         v_count     <= v_next;
         display_en  <= (h_next < H_VIS) && (v_next < V_VIS);
         line_start  <= (h_next == '0);
         frame_start <= (h_next == '0) && (v_next == '0);
         h_sync      <= (h_next >= HS_START && h_next < HS_END) ? H_ON : ~H_ON;
         v_sync      <= (v_next >= VS_START && v_next < VS_END) ? V_ON : ~V_ON;
      end
   end

   // Delay stage: matches downstream pixel-fetch latency in pix_ce ticks.
   ce_delay_line #(
      .WIDTH   (3),
      .DEPTH   (LATENCY),
      .RST_VAL ({~H_ON, ~V_ON, 1'b0})
   ) u_delay (
      .clk     (clk),
      .reset_n (reset_n),
      .ce      (pix_ce),
      .d       ({h_sync, v_sync, display_en}),
      .q       (dly)
   );

   assign vga.h_count      = h_count;
   assign vga.v_count      = v_count;
   assign vga.display_en   = display_en;
   assign vga.line_start   = line_start;
   assign vga.frame_start  = frame_start;
   assign vga.h_sync_d     = dly[2];
   assign vga.v_sync_d     = dly[1];
   assign vga.display_en_d = dly[0];

endmodule
